irq_seq: RTL and testbench

Parametrised interrupt/exception entry sequencer for the CPU. It generalises the single-line hardware interrupt path in the control unit to `NUM_IRQ` prioritised lines, each configurable as edge or level, with per-line masks and vectored entry. It adds in-service tracking so a higher-priority line can nest inside a running handler. It sits beside `cu`: the CU hands over at instruction boundaries and on decoded INT or illegal opcodes, and `irq_seq` drives the register-file, memory and status-load controls for the push-PC, push-STATUS and vector-load sequence.

---
 rtl/irq_seq_if.sv | 67 ++++++
 rtl/irq_seq.sv | 182 ++++++++++++++++++
 tb/tb_irq_seq.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_seq_if.sv
// Shared register/mode encodings and the CU-facing bus of the interrupt entry sequencer.
// The package precedes the interface so both compile from this one file.
package irq_seq_pkg;

    typedef enum logic [1:0] {
        RegNone   = 2'd0,
        RegPc     = 2'd1,
        RegSp     = 2'd2,
        RegStatus = 2'd3
    } reg_e;

    typedef enum logic {
        ModeUser       = 1'b0,
        ModeSupervisor = 1'b1
    } cpu_mode_e;

endpackage

interface irq_seq_if #(
    parameter int unsigned NUM_IRQ = 8
) ();

    localparam int unsigned IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    // CU / interrupt controller side
    logic               en;
    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] edge_mode;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               imask;
    logic               boundary;
    logic               swint_req;
    logic               except_req;
    logic               eoi;
    logic [IDW-1:0]     eoi_id;

    // Sequencer side
    logic                  take;
    logic                  busy;
    logic [IDW-1:0]        active_id;
    logic [NUM_IRQ-1:0]    pending;
    logic                  pre_dec_sp;
    logic                  wr;
    logic                  oe_a_reg;
    logic                  oe_b_reg;
    irq_seq_pkg::reg_e     sel_a_reg;
    irq_seq_pkg::reg_e     sel_b_reg;
    logic                  ld_pc;
    logic [31:0]           vector;
    logic                  ld_imask;
    logic                  imask_in;
    logic                  ld_mode;
    irq_seq_pkg::cpu_mode_e mode_in;

    modport master (
        output en, irq, edge_mode, irq_mask, imask, boundary, swint_req, except_req, eoi, eoi_id,
        input  take, busy, active_id, pending, pre_dec_sp, wr, oe_a_reg, oe_b_reg, sel_a_reg,
        input  sel_b_reg, ld_pc, vector, ld_imask, imask_in, ld_mode, mode_in
    );

    modport slave (
        input  en, irq, edge_mode, irq_mask, imask, boundary, swint_req, except_req, eoi, eoi_id,
        output take, busy, active_id, pending, pre_dec_sp, wr, oe_a_reg, oe_b_reg, sel_a_reg,
        output sel_b_reg, ld_pc, vector, ld_imask, imask_in, ld_mode, mode_in
    );

endinterface

// File: rtl/irq_seq.sv
// Interrupt/exception entry sequencer: prioritised, maskable, nestable hardware lines plus
// software interrupt and exception, driving the push-PC / push-STATUS / vector-load sequence.
module irq_seq
    import irq_seq_pkg::*;
#(
    parameter int unsigned NUM_IRQ        = 8,
    parameter logic [31:0] HW_VECTOR_BASE = 32'h10,
    parameter logic [31:0] SWINT_VECTOR   = 32'h2,
    parameter logic [31:0] EXCEPT_VECTOR  = 32'h3
) (
    input  logic     clk,
    input  logic     rst_n,
    irq_seq_if.slave bus_io
);

    localparam int unsigned IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StPushPc = 2'd1,
        StPushSt = 2'd2,
        StVector = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] in_service_q, in_service_d;
    logic [IDW-1:0]     active_id_q, active_id_d;
    logic [31:0]        vector_q, vector_d;

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] eligible;
    logic               hw_any;
    logic [IDW-1:0]     hw_id;
    logic               take;
    logic               hw_take;

    // Level lines bypass the latch; only edge lines use pend_q.
    assign pending = (bus_io.edge_mode & pend_q) | (~bus_io.edge_mode & bus_io.irq);

    // A line in service blocks itself and every lower-priority line.
    always_comb begin
        logic blk;
        blk      = 1'b0;
        eligible = '0;
        hw_any   = 1'b0;
        hw_id    = '0;
        for (int unsigned k = 0; k < NUM_IRQ; k++) begin
            blk         = blk | in_service_q[k];
            eligible[k] = pending[k] & bus_io.irq_mask[k] & bus_io.imask & ~blk;
            if (eligible[k] && !hw_any) begin
                hw_any = 1'b1;
                hw_id  = IDW'(k);
            end
        end
    end

    always_comb begin
        take    = 1'b0;
        hw_take = 1'b0;
        if (rst_n && bus_io.en && (state_q == StIdle)) begin
            if (bus_io.except_req || bus_io.swint_req) begin
                take = 1'b1;
            end else if (bus_io.boundary && hw_any) begin
                take    = 1'b1;
                hw_take = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        vector_d    = vector_q;
        active_id_d = active_id_q;
        if (bus_io.en) begin
            case (state_q)
                StIdle: begin
                    if (take) begin
                        state_d = StPushPc;
                        if (bus_io.except_req) begin
                            vector_d = EXCEPT_VECTOR;
                        end else if (bus_io.swint_req) begin
                            vector_d = SWINT_VECTOR;
                        end else begin
                            vector_d    = HW_VECTOR_BASE + 32'(hw_id);
                            active_id_d = hw_id;
                        end
                    end
                end
                StPushPc: state_d = StPushSt;
                StPushSt: state_d = StVector;
                StVector: state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Acceptance is applied after EOI so a same-cycle set on the same bit wins.
    always_comb begin
        in_service_d = in_service_q;
        if (bus_io.en) begin
            for (int unsigned k = 0; k < NUM_IRQ; k++) begin
                if (bus_io.eoi && (bus_io.eoi_id == IDW'(k))) begin
                    in_service_d[k] = 1'b0;
                end
                if (hw_take && (hw_id == IDW'(k))) begin
                    in_service_d[k] = 1'b1;
                end
            end
        end
    end

    // Edge detection runs regardless of en; a new edge beats the accept-clear.
    always_comb begin
        pend_d = '0;
        for (int unsigned k = 0; k < NUM_IRQ; k++) begin
            logic rise;
            logic clr;
            rise      = bus_io.irq[k] & ~irq_q[k];
            clr       = hw_take && (hw_id == IDW'(k));
            pend_d[k] = bus_io.edge_mode[k] & (rise | (pend_q[k] & ~clr));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            irq_q        <= '0;
            pend_q       <= '0;
            in_service_q <= '0;
            active_id_q  <= '0;
            vector_q     <= '0;
        end else begin
            state_q      <= state_d;
            irq_q        <= bus_io.irq;
            pend_q       <= pend_d;
            in_service_q <= in_service_d;
            active_id_q  <= active_id_d;
            vector_q     <= vector_d;
        end
    end

    always_comb begin
        bus_io.take       = take;
        bus_io.busy       = (state_q != StIdle);
        bus_io.pre_dec_sp = 1'b0;
        bus_io.wr         = 1'b0;
        bus_io.oe_a_reg   = 1'b0;
        bus_io.oe_b_reg   = 1'b0;
        bus_io.sel_a_reg  = RegNone;
        bus_io.sel_b_reg  = RegNone;
        bus_io.ld_pc      = 1'b0;
        bus_io.ld_imask   = 1'b0;
        bus_io.imask_in   = 1'b0;
        bus_io.ld_mode    = 1'b0;
        bus_io.mode_in    = ModeUser;
        case (state_q)
            StPushPc, StPushSt: begin
                bus_io.pre_dec_sp = 1'b1;
                bus_io.wr         = 1'b1;
                bus_io.oe_a_reg   = 1'b1;
                bus_io.oe_b_reg   = 1'b1;
                bus_io.sel_a_reg  = (state_q == StPushPc) ? RegPc : RegStatus;
                bus_io.sel_b_reg  = RegSp;
            end
            StVector: begin
                bus_io.ld_pc    = 1'b1;
                bus_io.ld_imask = 1'b1;
                bus_io.imask_in = 1'b0;
                bus_io.ld_mode  = 1'b1;
                bus_io.mode_in  = ModeSupervisor;
            end
            default: ;
        endcase
    end

    assign bus_io.active_id = active_id_q;
    assign bus_io.pending   = pending;
    assign bus_io.vector    = vector_q;

endmodule

// File: tb/tb_irq_seq.sv
// Bench for irq_seq: directed scenarios plus random traffic, every cycle's expected outputs
// come from a behavioural model and are queued for an independent monitor.
module tb_irq_seq;
    import irq_seq_pkg::*;

    localparam int unsigned N   = 8;
    localparam int unsigned IDW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    irq_seq_if #(.NUM_IRQ(N)) bus ();

    irq_seq #(
        .NUM_IRQ       (N),
        .HW_VECTOR_BASE(32'h10),
        .SWINT_VECTOR  (32'h2),
        .EXCEPT_VECTOR (32'h3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           take;
        logic           busy;
        logic [IDW-1:0] active_id;
        logic [N-1:0]   pending;
        logic           pre_dec_sp;
        logic           wr;
        logic           oe_a;
        logic           oe_b;
        reg_e           sel_a;
        reg_e           sel_b;
        logic           ld_pc;
        logic [31:0]    vector;
        logic           ld_imask;
        logic           imask_in;
        logic           ld_mode;
        cpu_mode_e      mode_in;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Values applied at the next falling edge
    logic           d_rst, d_en, d_imask, d_boundary, d_sw, d_exc, d_eoi;
    logic [N-1:0]   d_irq, d_edge, d_mask;
    logic [IDW-1:0] d_eoi_id;

    // Reference model state
    logic [N-1:0] m_pend, m_isv, m_prev;
    int           m_phase;
    logic [31:0]  m_vec;
    int           m_active;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    task automatic model_cycle();
        exp_t         e;
        logic [N-1:0] pv;
        bit           tk;
        bit           hw;
        int           win;
        logic [31:0]  nvec;
        if (!rst_n) begin
            m_pend = '0; m_isv = '0; m_prev = '0;
            m_phase = 0; m_vec = '0; m_active = 0;
        end
        for (int k = 0; k < N; k++) pv[k] = bus.edge_mode[k] ? m_pend[k] : bus.irq[k];
        tk = 0; hw = 0; win = -1; nvec = m_vec;
        if (rst_n && bus.en && m_phase == 0) begin
            if (bus.except_req) begin
                tk = 1; nvec = 32'h3;
            end else if (bus.swint_req) begin
                tk = 1; nvec = 32'h2;
            end else if (bus.boundary && bus.imask) begin
                // Scanning by priority: the first in-service line ends the search.
                for (int k = 0; k < N; k++) begin
                    if (m_isv[k]) break;
                    if (pv[k] && bus.irq_mask[k]) begin
                        win = k;
                        break;
                    end
                end
                if (win >= 0) begin
                    tk = 1; hw = 1; nvec = 32'h10 + win;
                end
            end
        end
        e = '0;
        e.take      = tk;
        e.busy      = (m_phase != 0);
        e.active_id = IDW'(m_active);
        e.pending   = pv;
        e.vector    = m_vec;
        e.sel_a     = RegNone;
        e.sel_b     = RegNone;
        e.mode_in   = ModeUser;
        if (m_phase == 1 || m_phase == 2) begin
            e.pre_dec_sp = 1; e.wr = 1; e.oe_a = 1; e.oe_b = 1;
            e.sel_a = (m_phase == 1) ? RegPc : RegStatus;
            e.sel_b = RegSp;
        end else if (m_phase == 3) begin
            e.ld_pc = 1; e.ld_imask = 1; e.ld_mode = 1; e.mode_in = ModeSupervisor;
        end
        exp_q.push_back(e);
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                m_pend[k] = bus.edge_mode[k] &&
                            ((bus.irq[k] && !m_prev[k]) || (m_pend[k] && !(hw && win == k)));
                m_prev[k] = bus.irq[k];
            end
            if (bus.en) begin
                if (bus.eoi && int'(bus.eoi_id) < N) m_isv[bus.eoi_id] = 1'b0;
                if (hw) begin
                    m_isv[win] = 1'b1;
                    m_active = win;
                end
                if (tk) begin
                    m_vec = nvec;
                    m_phase = 1;
                end else if (m_phase != 0) begin
                    m_phase = (m_phase + 1) % 4;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        rst_n          = d_rst;
        bus.en         = d_en;
        bus.irq        = d_irq;
        bus.edge_mode  = d_edge;
        bus.irq_mask   = d_mask;
        bus.imask      = d_imask;
        bus.boundary   = d_boundary;
        bus.swint_req  = d_sw;
        bus.except_req = d_exc;
        bus.eoi        = d_eoi;
        bus.eoi_id     = d_eoi_id;
        #1 model_cycle();
        #3;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drain any sequence, drop latched edges and retire every in-service line.
    task automatic clean();
        d_irq = '0; d_sw = 0; d_exc = 0; d_eoi = 0; d_en = 1; d_rst = 1;
        d_imask = 0; d_edge = '0; d_mask = '1; d_boundary = 1;
        ticks(5);
        for (int i = 0; i < N; i++) begin
            d_eoi = 1; d_eoi_id = IDW'(i);
            tick();
        end
        d_eoi = 0; d_eoi_id = '0; d_imask = 1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("take", bus.take, e.take);
                chk("busy", bus.busy, e.busy);
                chk("active_id", bus.active_id, e.active_id);
                chk("pending", bus.pending, e.pending);
                chk("push_ctrl", {bus.pre_dec_sp, bus.wr, bus.oe_a_reg, bus.oe_b_reg},
                    {e.pre_dec_sp, e.wr, e.oe_a, e.oe_b});
                chk("sel_a_reg", bus.sel_a_reg, e.sel_a);
                chk("sel_b_reg", bus.sel_b_reg, e.sel_b);
                chk("ld_pc", bus.ld_pc, e.ld_pc);
                chk("vector", bus.vector, e.vector);
                chk("status_ctrl", {bus.ld_imask, bus.imask_in, bus.ld_mode, bus.mode_in},
                    {e.ld_imask, e.imask_in, e.ld_mode, e.mode_in});
            end
        end
    end

    initial begin : stim
        d_rst = 0; d_en = 1; d_irq = '0; d_edge = '0; d_mask = '1; d_imask = 1;
        d_boundary = 1; d_sw = 0; d_exc = 0; d_eoi = 0; d_eoi_id = '0;
        tick();
        chk("reset take", bus.take, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset vector", bus.vector, 0);
        chk("reset active_id", bus.active_id, 0);
        chk("reset ctrl", {bus.wr, bus.ld_pc, bus.ld_mode, bus.pre_dec_sp}, 0);
        tick();
        d_rst = 1;
        ticks(2);

        // Edge line 3
        clean();
        d_edge = '1; tick();
        d_irq = 8'h08; tick();
        d_irq = 8'h00; tick();
        chk("edge3 take", bus.take, 1);
        tick();
        chk("edge3 push pc", {bus.wr, bus.sel_a_reg}, {1'b1, RegPc});
        tick();
        chk("edge3 push st", {bus.wr, bus.sel_a_reg}, {1'b1, RegStatus});
        tick();
        chk("edge3 ld_pc", bus.ld_pc, 1);
        chk("edge3 vector", bus.vector, 32'h13);
        chk("edge3 in_service", dut.in_service_q[3], 1);
        chk("edge3 pend cleared", bus.pending[3], 0);

        // Level lines 5 and 2
        clean();
        d_irq = 8'h24; tick();
        chk("lvl take 2", bus.take, 1);
        ticks(3);
        chk("lvl vector 2", bus.vector, 32'h12);
        d_irq = 8'h20; tick();
        chk("lvl 5 blocked", bus.take, 0);
        d_eoi = 1; d_eoi_id = 3'd2; tick();
        chk("lvl 5 blocked at eoi", bus.take, 0);
        d_eoi = 0; tick();
        chk("lvl take 5", bus.take, 1);
        ticks(3);
        chk("lvl vector 5", bus.vector, 32'h15);

        // Nesting under line 4
        clean();
        d_irq = 8'h10; tick();
        d_irq = 8'h00; ticks(3);
        d_irq = 8'h40; tick();
        chk("nest 6 blocked", bus.take, 0);
        d_irq = 8'h42; tick();
        chk("nest take 1", bus.take, 1);
        d_irq = 8'h40; ticks(3);
        chk("nest vector 1", bus.vector, 32'h11);
        d_eoi = 1; d_eoi_id = 3'd1; tick();
        d_eoi = 0; d_irq = 8'h50; tick();
        chk("nest 4 blocked", bus.take, 0);
        d_eoi = 1; d_eoi_id = 3'd4; tick();
        d_eoi = 0; tick();
        chk("nest take 4", bus.take, 1);
        ticks(3);
        chk("nest vector 4", bus.vector, 32'h14);

        // Exception beats software interrupt
        clean();
        d_imask = 0; d_exc = 1; d_sw = 1; tick();
        chk("exc take", bus.take, 1);
        d_exc = 0; d_sw = 0; ticks(3);
        chk("exc vector", bus.vector, 32'h3);
        tick();
        chk("swint dropped", bus.take, 0);
        d_sw = 1; tick();
        d_sw = 0; ticks(3);
        chk("swint vector", bus.vector, 32'h2);

        // Masked edge on line 0
        clean();
        d_edge = 8'h01; d_mask = 8'hFE; tick();
        d_irq = 8'h01; tick();
        d_irq = 8'h00; tick();
        chk("masked pending0", bus.pending[0], 1);
        chk("masked no take", bus.take, 0);
        d_mask = 8'hFF; tick();
        chk("unmasked take", bus.take, 1);
        ticks(3);
        chk("unmasked vector", bus.vector, 32'h10);

        // Reset during PUSH_ST
        clean();
        d_irq = 8'h08; tick();
        d_irq = 8'h00; tick();
        d_rst = 0; tick();
        chk("abort outputs", {bus.wr, bus.busy, bus.sel_a_reg, bus.ld_pc, bus.vector}, 0);
        chk("abort in_service", dut.in_service_q, 0);
        d_rst = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort no ld_pc", bus.ld_pc, 0);
        end

        // Stall during PUSH_PC
        clean();
        d_sw = 1; tick();
        d_sw = 0; d_en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall hold", {bus.wr, bus.sel_a_reg, bus.take}, {1'b1, RegPc, 1'b0});
        end
        d_en = 1; tick();
        chk("resume pc", bus.sel_a_reg, RegPc);
        tick();
        chk("resume st", bus.sel_a_reg, RegStatus);
        tick();
        chk("resume ld_pc", {bus.ld_pc, bus.vector}, {1'b1, 32'h2});

        // Random traffic
        clean();
        for (int c = 0; c < 1500; c++) begin
            if (c % 200 == 0) d_edge = N'($urandom);
            d_rst      = ($urandom_range(0, 499) != 0);
            d_en       = ($urandom_range(0, 15) != 0);
            d_imask    = ($urandom_range(0, 9) != 0);
            d_boundary = ($urandom_range(0, 3) != 0);
            d_mask     = N'($urandom) | N'($urandom);
            d_sw       = ($urandom_range(0, 39) == 0);
            d_exc      = ($urandom_range(0, 59) == 0);
            d_eoi      = ($urandom_range(0, 5) == 0);
            d_eoi_id   = IDW'($urandom_range(0, N - 1));
            for (int k = 0; k < N; k++) if ($urandom_range(0, 11) == 0) d_irq[k] = ~d_irq[k];
            tick();
        end
        d_rst = 1;
        clean();

        @(negedge clk);
        #6;
        chk("scoreboard drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
